seg_serial_display: RTL and testbench

- Board-level top block that drives an 8-digit 7-segment display through a serial shift-register interface (SEGCLK/SEGCLR/SEGDT/SEGEN).
- Continuously shows the hex value of an internal 32-bit frame counter.
- The counter increments once per transmitted frame, so each frame's content is predictable.
- Sits at the top of the NPC FPGA build; its outputs go straight to the display pins.

---
 rtl/seg_serial_display_if.sv | 34 +++
 rtl/seg_serial_display.sv | 207 ++++++++++++++++++++
 tb/tb_seg_serial_display.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_serial_display_if.sv
// rtl/seg_serial_display_if.sv - serial 7-segment display pin bundle
//
// Purpose: groups the four display shift-register pins so the driver and
//          whatever sits on the other side (board pins, bench) share one
//          declaration.
// Signals:
//   SEGCLK  serial shift clock; the display samples SEGDT on its rising edge
//   SEGCLR  active-low clear of the display shift register
//   SEGDT   serial segment data, MSB first
//   SEGEN   latch/enable; low while shifting, rising edge latches 64 bits
// Modports:
//   master  drives all four pins (the display driver)
//   slave   observes all four pins (display / monitor side)

interface seg_serial_display_if;
    logic SEGCLK;
    logic SEGCLR;
    logic SEGDT;
    logic SEGEN;

    modport master (
        output SEGCLK,
        output SEGCLR,
        output SEGDT,
        output SEGEN
    );

    modport slave (
        input SEGCLK,
        input SEGCLR,
        input SEGDT,
        input SEGEN
    );
endinterface

// File: rtl/seg_serial_display.sv
// rtl/seg_serial_display.sv - 8-digit serial 7-segment driver showing a frame counter
//
// Purpose: continuously shifts a 64-bit frame (8 active-low segment bytes,
//          digit 7 first) into an external display shift register. The value
//          shown is an internal 32-bit counter that advances once per frame.
// Parameters:
//   DIV         clk cycles per SEGCLK half-period (>= 1)
//   GAP         clk cycles SEGEN is held high after each frame (>= 1)
//   CLR_CYCLES  clk cycles SEGCLR is held low after reset release (>= 1)
//   INIT_COUNT  frame-counter value loaded on reset
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   sysclk_n  negative leg of the board differential clock, not used
//   seg       display pins (SEGCLK/SEGCLR/SEGDT/SEGEN), all registered

module seg_serial_display #(
    parameter int          DIV        = 2,
    parameter int          GAP        = 8,
    parameter int          CLR_CYCLES = 4,
    parameter logic [31:0] INIT_COUNT = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sysclk_n,
    seg_serial_display_if.master   seg
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    // Terminal values of the shared tick counter for each timed phase.
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
    localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);

    // The differential clock leg is only present for pin compatibility.
    logic w_unused_sysclk_n;
    assign w_unused_sysclk_n = sysclk_n;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_tick;
    logic [15:0] w_tick_next;
    logic [5:0]  r_bit;
    logic [5:0]  w_bit_next;
    logic [63:0] r_frame;
    logic [63:0] w_frame_next;
    logic [31:0] r_count;
    logic [31:0] w_count_next;
    logic        r_segclk;
    logic        w_segclk_next;
    logic        r_segclr;
    logic        w_segclr_next;
    logic        r_segdt;
    logic        w_segdt_next;
    logic        r_segen;
    logic        w_segen_next;
    logic [63:0] w_load_frame;

    // Hex digit -> display byte {dp_n, g_n..a_n}; segments are active-low and
    // the decimal point is never lit.
    function automatic logic [7:0] f_encode(input logic [3:0] i_nib);
        logic [6:0] v_lit;
        case (i_nib)
            4'h0: v_lit = 7'h3F;
            4'h1: v_lit = 7'h06;
            4'h2: v_lit = 7'h5B;
            4'h3: v_lit = 7'h4F;
            4'h4: v_lit = 7'h66;
            4'h5: v_lit = 7'h6D;
            4'h6: v_lit = 7'h7D;
            4'h7: v_lit = 7'h07;
            4'h8: v_lit = 7'h7F;
            4'h9: v_lit = 7'h6F;
            4'hA: v_lit = 7'h77;
            4'hB: v_lit = 7'h7C;
            4'hC: v_lit = 7'h39;
            4'hD: v_lit = 7'h5E;
            4'hE: v_lit = 7'h79;
            default: v_lit = 7'h71;
        endcase
        return {1'b1, ~v_lit};
    endfunction

    // Digit d of the counter lands in byte d of the frame, so digit 7 sits in
    // the top byte and leaves first.
    always_comb begin
        w_load_frame = '0;
        for (int d = 0; d < 8; d++) begin
            w_load_frame[8*d +: 8] = f_encode(r_count[4*d +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_CLEAR;
            r_tick   <= '0;
            r_bit    <= '0;
            r_frame  <= '0;
            r_count  <= INIT_COUNT;
            r_segclk <= 1'b0;
            r_segclr <= 1'b0;
            r_segdt  <= 1'b0;
            r_segen  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_tick   <= w_tick_next;
            r_bit    <= w_bit_next;
            r_frame  <= w_frame_next;
            r_count  <= w_count_next;
            r_segclk <= w_segclk_next;
            r_segclr <= w_segclr_next;
            r_segdt  <= w_segdt_next;
            r_segen  <= w_segen_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick;
        w_bit_next    = r_bit;
        w_frame_next  = r_frame;
        w_count_next  = r_count;
        w_segclk_next = r_segclk;
        w_segclr_next = r_segclr;
        w_segdt_next  = r_segdt;
        w_segen_next  = r_segen;

        case (r_state)
            S_CLEAR: begin
                // SEGCLR rises on the CLR_CYCLES-th edge after release and
                // is never lowered again outside of reset.
                if (r_tick == CLR_LAST) begin
                    w_segclr_next = 1'b1;
                    w_tick_next   = '0;
                    w_state_next  = S_LOAD;
                end else begin
                    w_tick_next = r_tick + 16'd1;
                end
            end

            S_LOAD: begin
                // Present the first bit together with the low SEGCLK phase so
                // it is settled well before the first rising edge.
                w_frame_next  = w_load_frame;
                w_segdt_next  = w_load_frame[63];
                w_segclk_next = 1'b0;
                w_segen_next  = 1'b0;
                w_tick_next   = '0;
                w_bit_next    = '0;
                w_state_next  = S_SHIFT;
            end

            S_SHIFT: begin
                if (r_tick != DIV_LAST) begin
                    w_tick_next = r_tick + 16'd1;
                end else begin
                    w_tick_next = '0;
                    if (!r_segclk) begin
                        w_segclk_next = 1'b1;
                    end else if (r_bit == 6'd63) begin
                        // Last high phase done: latch, and advance the counter
                        // on the same edge SEGEN rises. SEGDT keeps its value.
                        w_segclk_next = 1'b0;
                        w_segen_next  = 1'b1;
                        w_count_next  = r_count + 32'd1;
                        w_state_next  = S_LATCH;
                    end else begin
                        // Falling SEGCLK and the next data bit change together;
                        // the frame register shifts so bit [63] is always the
                        // one on the wire.
                        w_segclk_next = 1'b0;
                        w_bit_next    = r_bit + 6'd1;
                        w_frame_next  = {r_frame[62:0], 1'b0};
                        w_segdt_next  = r_frame[62];
                    end
                end
            end

            S_LATCH: begin
                if (r_tick == GAP_LAST) begin
                    w_segen_next = 1'b0;
                    w_tick_next  = '0;
                    w_state_next = S_LOAD;
                end else begin
                    w_tick_next = r_tick + 16'd1;
                end
            end

            default: begin
                w_state_next = S_CLEAR;
                w_tick_next  = '0;
            end
        endcase
    end

    assign seg.SEGCLK = r_segclk;
    assign seg.SEGCLR = r_segclr;
    assign seg.SEGDT  = r_segdt;
    assign seg.SEGEN  = r_segen;

endmodule

// File: tb/tb_seg_serial_display.sv
// tb/tb_seg_serial_display.sv - self-checking bench for seg_serial_display

module tb_seg_serial_display;

    localparam int DIV        = 2;
    localparam int GAP        = 8;
    localparam int CLR_CYCLES = 4;
    localparam int PERIOD     = 1 + 128*DIV + GAP;

    localparam logic [6:0] LIT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic sysclk_n = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;
    always #3 sysclk_n = ~sysclk_n;

    seg_serial_display_if ifa ();
    seg_serial_display_if ifb ();
    seg_serial_display_if ifc ();

    seg_serial_display #(.DIV(DIV), .GAP(GAP), .CLR_CYCLES(CLR_CYCLES), .INIT_COUNT(32'h0))
        dut_a (.clk(clk), .rst(rst_a), .sysclk_n(sysclk_n), .seg(ifa));
    seg_serial_display #(.DIV(DIV), .GAP(GAP), .CLR_CYCLES(CLR_CYCLES), .INIT_COUNT(32'hFFFF_FFFE))
        dut_b (.clk(clk), .rst(rst_b), .sysclk_n(sysclk_n), .seg(ifb));
    seg_serial_display #(.DIV(DIV), .GAP(GAP), .CLR_CYCLES(CLR_CYCLES), .INIT_COUNT(32'h0))
        dut_c (.clk(clk), .rst(rst_a), .sysclk_n(1'b0), .seg(ifc));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder per display: bit sampled at each SEGCLK rise, cycle of
    // each rise, cycle of each SEGEN rise and length of each SEGEN pulse.
    logic mclk [2];
    logic mdt  [2];
    logic men  [2];
    logic mrst [2];
    assign mclk[0] = ifa.SEGCLK;
    assign mdt[0]  = ifa.SEGDT;
    assign men[0]  = ifa.SEGEN;
    assign mrst[0] = rst_a;
    assign mclk[1] = ifb.SEGCLK;
    assign mdt[1]  = ifb.SEGDT;
    assign men[1]  = ifb.SEGEN;
    assign mrst[1] = rst_b;

    bit   bitq  [2][$];
    int   riseq [2][$];
    int   enq   [2][$];
    int   enlen [2][$];
    logic pclk  [2] = '{1'b0, 1'b0};
    logic pen   [2] = '{1'b0, 1'b0};
    int   encnt [2] = '{0, 0};
    int   en_shift_bad [2] = '{0, 0};
    int   trace_diff = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!mrst[k]) begin
                pclk[k]  <= 1'b0;
                pen[k]   <= 1'b0;
                encnt[k] <= 0;
            end else begin
                if (mclk[k] && !pclk[k]) begin
                    bitq[k].push_back(mdt[k]);
                    riseq[k].push_back(cyc);
                    if (men[k]) en_shift_bad[k] <= en_shift_bad[k] + 1;
                end
                if (men[k] && !pen[k]) enq[k].push_back(cyc);
                if (men[k]) encnt[k] <= encnt[k] + 1;
                else if (pen[k]) begin
                    enlen[k].push_back(encnt[k]);
                    encnt[k] <= 0;
                end
                pclk[k] <= mclk[k];
                pen[k]  <= men[k];
            end
        end
    end

    // dut_c differs from dut_a only in a constant sysclk_n.
    always @(negedge clk) begin
        if ({ifa.SEGCLK, ifa.SEGCLR, ifa.SEGDT, ifa.SEGEN} !==
            {ifc.SEGCLK, ifc.SEGCLR, ifc.SEGDT, ifc.SEGEN})
            trace_diff <= trace_diff + 1;
    end

    // Reference: 8 bytes, most significant digit first, each 0x80 | ~lit.
    function automatic logic [63:0] model_frame(input logic [31:0] v);
        logic [63:0] f;
        int nib;
        f = '0;
        for (int d = 7; d >= 0; d--) begin
            nib = int'((v >> (4*d)) & 32'hF);
            f = (f << 8) | 64'(8'h80 | {1'b0, ~LIT[nib]});
        end
        return f;
    endfunction

    function automatic logic [63:0] gather(input int k, input int start);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 64; i++) begin
            if (start + i < bitq[k].size()) f = {f[62:0], logic'(bitq[k][start + i])};
            else f = {f[62:0], 1'bx};
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int k, input int n, input string tag);
        for (int w = 0; w < 4000 && bitq[k].size() < n; w++) @(negedge clk);
        chk(tag, 64'(bitq[k].size() >= n), 64'd1);
    endtask

    task automatic clear_phase(input string tag, output int rise_cyc);
        int nlow;
        @(negedge clk);
        rst_a = 1'b1;
        nlow = 0;
        for (int w = 0; w < 50 && ifa.SEGCLR === 1'b0; w++) begin
            nlow++;
            @(negedge clk);
        end
        chk({tag, "_segclr_low"}, 64'(nlow), 64'(CLR_CYCLES));
        rise_cyc = cyc;
    endtask

    int base_a, base_b, eb_a, eb_b, clr_rise, bad;
    logic [31:0] cnt_b;

    initial begin
        // Both held in reset with clocks running.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("reset_a", {60'd0, ifa.SEGCLK, ifa.SEGCLR, ifa.SEGDT, ifa.SEGEN}, 64'd0);
            chk("reset_b", {60'd0, ifb.SEGCLK, ifb.SEGCLR, ifb.SEGDT, ifb.SEGEN}, 64'd0);
        end

        // Wrap and encoding: three frames from FFFFFFFE.
        base_b = bitq[1].size();
        eb_b   = enq[1].size();
        @(negedge clk);
        rst_b = 1'b1;
        wait_bits(1, base_b + 192, "wait_b_frames");
        for (int w = 0; w < 100 && enlen[1].size() < eb_b + 3; w++) @(negedge clk);
        cnt_b = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b_frame%0d", i + 1), gather(1, base_b + 64*i), model_frame(cnt_b + 32'(i)));
            chk($sformatf("b_gap%0d", i + 1), 64'(enlen[1][eb_b + i]), 64'(GAP));
        end
        chk("b_spacing12", 64'(enq[1][eb_b + 1] - enq[1][eb_b]), 64'(PERIOD));
        chk("b_spacing23", 64'(enq[1][eb_b + 2] - enq[1][eb_b + 1]), 64'(PERIOD));
        chk("a_still_reset", {60'd0, ifa.SEGCLK, ifa.SEGCLR, ifa.SEGDT, ifa.SEGEN}, 64'd0);

        // Clear phase and first two frames from 0.
        base_a = bitq[0].size();
        eb_a   = enq[0].size();
        clear_phase("a1", clr_rise);
        wait_bits(0, base_a + 148, "wait_a_frames");
        chk("a_first_rise", 64'(riseq[0][base_a] - clr_rise), 64'(1 + DIV));
        chk("a_frame1", gather(0, base_a), model_frame(32'd0));
        chk("a_frame2", gather(0, base_a + 64), model_frame(32'd1));
        bad = 0;
        for (int i = 1; i < 64; i++)
            if (riseq[0][base_a + i] - riseq[0][base_a + i - 1] != 2*DIV) bad++;
        chk("a_sclk_period", 64'(bad), 64'd0);
        chk("a_gap1", 64'(enlen[0][eb_a]), 64'(GAP));
        chk("a_spacing12", 64'(enq[0][eb_a + 1] - enq[0][eb_a]), 64'(PERIOD));
        chk("a_en_during_shift", 64'(en_shift_bad[0]), 64'd0);
        chk("b_en_during_shift", 64'(en_shift_bad[1]), 64'd0);

        // Mid-frame asynchronous reset, 20 bits into the third frame.
        @(posedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        chk("async_segclk", 64'(ifa.SEGCLK), 64'd0);
        chk("async_segclr", 64'(ifa.SEGCLR), 64'd0);
        chk("async_segdt",  64'(ifa.SEGDT),  64'd0);
        chk("async_segen",  64'(ifa.SEGEN),  64'd0);
        repeat (3) @(negedge clk);
        base_a = bitq[0].size();
        clear_phase("a2", clr_rise);
        wait_bits(0, base_a + 64, "wait_a_restart");
        chk("a2_first_rise", 64'(riseq[0][base_a] - clr_rise), 64'(1 + DIV));
        chk("a2_frame1", gather(0, base_a), model_frame(32'd0));
        repeat (20) @(negedge clk);
        chk("sysclk_n_no_effect", 64'(trace_diff), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
